// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage RV32 pipeline.
// It shadows EX/MEM/WB destinations and derives forwarding selects, load-use stalls and branch flushes.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rr1,
  input  logic             id_rr2,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_wen,
  input  logic [1:0]       id_wb_sel,
  input  logic             ex_br_taken,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             flush_ifid,
  output logic             bubble_idex,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] WB_DM = 2'd1;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wen;
    logic [1:0] wb_sel;
  } stage_t;

  stage_t ex_q, mem_q, wb_q;
  logic   lu;

  function automatic logic writes(stage_t s, logic [4:0] r);
    return s.valid & s.wen & (s.rd != 5'd0) & (s.rd == r);
  endfunction

  // A load in EX cannot forward yet; that case is covered by the stall.
  function automatic logic [1:0] fwd_sel(logic rr, logic [4:0] rs,
                                         stage_t ex, stage_t mem, stage_t wb);
    if (!rr || rs == 5'd0) return 2'd0;
    if (writes(ex, rs))    return (ex.wb_sel == WB_DM) ? 2'd0 : 2'd1;
    if (writes(mem, rs))   return 2'd2;
    if (writes(wb, rs))    return 2'd3;
    return 2'd0;
  endfunction

  assign lu = id_valid & (ex_q.wb_sel == WB_DM) &
              ((id_rr1 & writes(ex_q, id_rs1)) | (id_rr2 & writes(ex_q, id_rs2)));

  always_comb begin
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    flush_ifid  = 1'b0;
    bubble_idex = 1'b0;
    fwd_a       = 2'd0;
    fwd_b       = 2'd0;
    if (!rst) begin
      if (ex_br_taken) begin
        flush_ifid  = 1'b1;
        bubble_idex = 1'b1;
      end else if (lu) begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        bubble_idex = 1'b1;
      end
      if (!lu) begin
        fwd_a = fwd_sel(id_rr1, id_rs1, ex_q, mem_q, wb_q);
        fwd_b = fwd_sel(id_rr2, id_rs2, ex_q, mem_q, wb_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= bubble_idex ? '0 : {id_valid, id_rd, id_reg_wen, id_wb_sel};
      if (lu && !ex_br_taken && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + 1'b1;
      if (ex_br_taken && flush_cnt != {CNT_W{1'b1}})
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed instruction sequences checked against
// an in-flight-instruction list model every cycle plus literal spot checks.
module tb_hazard_ctrl;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          id_valid = 0, id_rr1 = 0, id_rr2 = 0, id_reg_wen = 0, ex_br_taken = 0;
  logic [4:0]    id_rs1 = 0, id_rs2 = 0, id_rd = 0;
  logic [1:0]    id_wb_sel = 0;
  logic          stall_pc, stall_ifid, flush_ifid, bubble_idex;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  hazard_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rr1(id_rr1), .id_rr2(id_rr2), .id_rd(id_rd), .id_reg_wen(id_reg_wen),
    .id_wb_sel(id_wb_sel), .ex_br_taken(ex_br_taken), .stall_pc(stall_pc),
    .stall_ifid(stall_ifid), .flush_ifid(flush_ifid), .bubble_idex(bubble_idex),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: list of the three older instructions, index 0 = youngest (EX).
  typedef struct { bit v; int rd; bit wen; int sel; } ent_t;
  ent_t sh[3];
  int   m_stall = 0;
  int   m_flush = 0;

  function automatic bit m_writes(int k, int r);
    return sh[k].v && sh[k].wen && sh[k].rd != 0 && sh[k].rd == r;
  endfunction

  function automatic bit m_lu();
    return id_valid && sh[0].sel == 1 &&
           ((id_rr1 && m_writes(0, int'(id_rs1))) || (id_rr2 && m_writes(0, int'(id_rs2))));
  endfunction

  function automatic int m_fwd(bit rr, int rs);
    if (!rr || rs == 0 || m_lu()) return 0;
    for (int k = 0; k < 3; k++)
      if (m_writes(k, rs)) return (k == 0 && sh[0].sel == 1) ? 0 : k + 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    bit lu;
    lu = m_lu();
    if (rst) begin
      for (int k = 0; k < 3; k++) sh[k] = '{0, 0, 0, 0};
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (lu && !ex_br_taken && m_stall < CMAX) m_stall++;
      if (ex_br_taken && m_flush < CMAX) m_flush++;
      sh[2] = sh[1];
      sh[1] = sh[0];
      if (lu || ex_br_taken) sh[0] = '{0, 0, 0, 0};
      else sh[0] = '{id_valid, int'(id_rd), id_reg_wen, int'(id_wb_sel)};
    end
  end

  always @(negedge clk) begin
    bit lu, br;
    lu = !rst && m_lu();
    br = !rst && ex_br_taken;
    chk("m_stall_pc",   32'(stall_pc),    32'(lu && !br));
    chk("m_stall_ifid", 32'(stall_ifid),  32'(lu && !br));
    chk("m_flush_ifid", 32'(flush_ifid),  32'(br));
    chk("m_bubble",     32'(bubble_idex), 32'(lu || br));
    chk("m_fwd_a",      32'(fwd_a),       rst ? 0 : 32'(m_fwd(id_rr1, int'(id_rs1))));
    chk("m_fwd_b",      32'(fwd_b),       rst ? 0 : 32'(m_fwd(id_rr2, int'(id_rs2))));
    chk("m_stall_cnt",  32'(stall_cnt),   32'(m_stall));
    chk("m_flush_cnt",  32'(flush_cnt),   32'(m_flush));
  end

  task automatic ins(input bit v, input logic [4:0] rs1, input bit rr1, input logic [4:0] rs2,
                     input bit rr2, input logic [4:0] rd, input bit wen, input logic [1:0] sel,
                     input bit br);
    @(posedge clk);
    #1;
    id_valid = v; id_rs1 = rs1; id_rr1 = rr1; id_rs2 = rs2; id_rr2 = rr2;
    id_rd = rd; id_reg_wen = wen; id_wb_sel = sel; ex_br_taken = br;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) ins(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    chk("reset_stall_pc", 32'(stall_pc), 0);
    chk("reset_stall_cnt", 32'(stall_cnt), 0);
    @(posedge clk);
    #1 rst = 0;
    idle(1);

    // ALU-to-ALU forwarding distances
    ins(1, 1, 1, 2, 1, 5, 1, 0, 0);
    ins(1, 5, 1, 1, 1, 6, 1, 0, 0);
    chk("alu_fwd_ex", 32'(fwd_a), 1);
    chk("alu_no_stall", 32'(stall_pc), 0);
    idle(3);
    ins(1, 1, 1, 2, 1, 5, 1, 0, 0);
    ins(1, 11, 1, 12, 1, 10, 1, 0, 0);
    ins(1, 5, 1, 1, 1, 6, 1, 0, 0);
    chk("alu_fwd_mem", 32'(fwd_a), 2);
    idle(3);
    ins(1, 1, 1, 2, 1, 5, 1, 0, 0);
    ins(1, 11, 1, 12, 1, 10, 1, 0, 0);
    ins(1, 11, 1, 12, 1, 10, 1, 0, 0);
    ins(1, 5, 1, 1, 1, 6, 1, 0, 0);
    chk("alu_fwd_wb", 32'(fwd_a), 3);
    idle(3);

    // load-use: one stall cycle, then MEM forward on both operands
    ins(1, 1, 1, 0, 0, 7, 1, 1, 0);
    ins(1, 7, 1, 7, 1, 8, 1, 0, 0);
    chk("lu_stall_pc", 32'(stall_pc), 1);
    chk("lu_bubble", 32'(bubble_idex), 1);
    chk("lu_cnt_before", 32'(stall_cnt), 0);
    ins(1, 7, 1, 7, 1, 8, 1, 0, 0);
    chk("lu_released", 32'(stall_pc), 0);
    chk("lu_fwd_a", 32'(fwd_a), 2);
    chk("lu_fwd_b", 32'(fwd_b), 2);
    chk("lu_cnt_after", 32'(stall_cnt), 1);
    idle(3);

    // x0 and read flags
    ins(1, 1, 1, 2, 1, 0, 1, 0, 0);
    ins(1, 0, 1, 0, 1, 4, 1, 0, 0);
    chk("x0_fwd_a", 32'(fwd_a), 0);
    chk("x0_fwd_b", 32'(fwd_b), 0);
    idle(3);
    ins(1, 0, 0, 0, 0, 9, 1, 0, 0);
    ins(1, 9, 0, 0, 0, 1, 1, 2, 0);
    chk("jal_fwd_a", 32'(fwd_a), 0);
    chk("jal_no_stall", 32'(stall_pc), 0);
    idle(3);

    // x3 in EX, MEM and WB at once
    ins(1, 1, 1, 2, 1, 3, 1, 0, 0);
    ins(1, 1, 1, 2, 1, 3, 1, 0, 0);
    ins(1, 1, 1, 2, 1, 3, 1, 0, 0);
    ins(1, 3, 1, 0, 0, 4, 1, 0, 0);
    chk("prio_fwd_a", 32'(fwd_a), 1);
    idle(3);

    // back-to-back loads each feeding the next
    ins(1, 1, 1, 0, 0, 7, 1, 1, 0);
    ins(1, 7, 1, 0, 0, 8, 1, 1, 0);
    chk("b2b_stall1", 32'(stall_pc), 1);
    ins(1, 7, 1, 0, 0, 8, 1, 1, 0);
    chk("b2b_go1", 32'(stall_pc), 0);
    ins(1, 8, 1, 0, 0, 9, 1, 0, 0);
    chk("b2b_stall2", 32'(stall_pc), 1);
    ins(1, 8, 1, 0, 0, 9, 1, 0, 0);
    chk("b2b_go2", 32'(stall_pc), 0);
    idle(3);
    chk("b2b_stall_cnt", 32'(stall_cnt), 3);

    // flush colliding with load-use
    ins(1, 1, 1, 0, 0, 7, 1, 1, 0);
    ins(1, 7, 1, 7, 1, 8, 1, 0, 1);
    chk("col_flush", 32'(flush_ifid), 1);
    chk("col_bubble", 32'(bubble_idex), 1);
    chk("col_stall_pc", 32'(stall_pc), 0);
    idle(1);
    chk("col_flush_cnt", 32'(flush_cnt), 1);
    chk("col_stall_cnt", 32'(stall_cnt), 3);
    idle(3);

    // reset raised during a stall
    ins(1, 1, 1, 0, 0, 7, 1, 1, 0);
    @(posedge clk);
    #1;
    id_valid = 1; id_rs1 = 7; id_rr1 = 1; id_rs2 = 7; id_rr2 = 1;
    id_rd = 8; id_reg_wen = 1; id_wb_sel = 0; ex_br_taken = 0; rst = 1;
    @(negedge clk);
    chk("rst_stall_pc", 32'(stall_pc), 0);
    chk("rst_bubble", 32'(bubble_idex), 0);
    chk("rst_fwd_a", 32'(fwd_a), 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("post_rst_stall", 32'(stall_pc), 0);
    chk("post_rst_fwd_a", 32'(fwd_a), 0);
    chk("post_rst_scnt", 32'(stall_cnt), 0);
    chk("post_rst_fcnt", 32'(flush_cnt), 0);

    // flush counter saturation
    repeat (CMAX + 4) ins(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    chk("flush_cnt_sat", 32'(flush_cnt), CMAX);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage RV32 core. It consumes the per-instruction decode outputs (register-read flags, register-write enable, writeback select) and tracks the destination register of every in-flight instruction in its own EX/MEM/WB shadow pipeline. From that state it drives forwarding selects, load-use stalls and branch flushes. It sits beside the ID stage and is stepped once per cycle, in lockstep with the pipeline registers.

## Interface
- Parameters:
- `CNT_W`, default 16: width of the saturating stall and flush event counters.
- Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  ID stage holds a real instruction.
- `id_rs1`, `id_rs2`  in  5 each  source register indices of the ID instruction.
- `id_rr1`, `id_rr2`  in  1 each  ID instruction reads rs1 / rs2 (decoder `rr1`/`rr2`).
- `id_rd`  in  5  destination index of the ID instruction.
- `id_reg_wen`  in  1  ID instruction writes rd (decoder `regWEn`).
- `id_wb_sel`  in  2  decoder `wbSel`: 0 = FROM_ALU, 1 = FROM_DM, 2 = PC4.
- `ex_br_taken`  in  1  EX stage resolved a taken branch or a jump; redirect this cycle.
- `stall_pc`, `stall_ifid`  out  1 each  hold PC and IF/ID.
- `flush_ifid`  out  1  squash IF/ID.
- `bubble_idex`  out  1  load a NOP into ID/EX.
- `fwd_a`, `fwd_b`  out  2 each  operand source for the ID instruction, latched into ID/EX: 0 = regfile, 1 = EX result, 2 = MEM result, 3 = WB result.
- `stall_cnt`, `flush_cnt`  out  `CNT_W` each  saturating event counters.

## Operation
- Shadow pipeline:
  - Three entries `ex`, `mem`, `wb`, each holding {valid, rd, wen, wb_sel}.
  - Each cycle: `wb` <= `mem`; `mem` <= `ex`; `ex` <= the ID fields, or a bubble (valid = 0) when `bubble_idex` is 1.
- Write-hazard qualifier for a stage s: `s.valid & s.wen & (s.rd != 0)`. Register x0 never creates a hazard or a forward.
- Load-use hazard (`lu`):
  - Condition: `id_valid`, and `ex` qualifies as a writer with `ex.wb_sel == 1`, and (`id_rr1 & id_rs1 == ex.rd`) or (`id_rr2 & id_rs2 == ex.rd`).
  - Response: `stall_pc = stall_ifid = bubble_idex = 1`.
- Forward select for operand A (operand B is identical, using rs2/rr2):
  - If `id_rr1` = 0, or `id_rs1` = 0: the select is 0.
  - Otherwise the first qualifying match wins, in priority EX (1), then MEM (2), then WB (3), else 0.
  - An EX match with `ex.wb_sel == 1` is the load-use case: the select is don't-care and is driven 0 while stalled.
- Branch flush:
  - `ex_br_taken` = 1 forces `flush_ifid = bubble_idex = 1`.
  - It also forces `stall_pc = stall_ifid = 0`, so the PC takes the redirect.
  - Flush overrides a simultaneous load-use stall: the squashed ID instruction must not stall.
- Counters:
  - `stall_cnt` increments on each cycle with `lu & ~ex_br_taken`.
  - `flush_cnt` increments on each cycle with `ex_br_taken`.
  - Both saturate at all-ones and never wrap.
- Reset: all shadow entries invalid, both counters 0. Every control output is 0 while `rst` is high, regardless of the inputs.

## Timing
- Control outputs are combinational from the current inputs and the registered shadow state, with zero-cycle latency. They are valid before the same rising edge that updates the pipeline registers.
- A load-use stall lasts exactly one cycle:
  - Cycle N: the stall is asserted.
  - At edge N+1 the load moves to `mem` and `ex` becomes a bubble.
  - In cycle N+1 the same ID instruction sees `fwd` = 2 and no stall.
- Back-to-back loads, each feeding the next, stall once per pair.
- The shadow state advances every cycle; a stall only replaces the `ex` input with a bubble, and `mem`/`wb` keep draining.
- Reset asserted mid-stall: on the next edge all state clears and the outputs are 0 from that cycle on. There is no carry-over.
- Counter updates are registered and visible the cycle after the event.

## Test plan
- ALU-to-ALU chain: `add x5,...`, then `sub x6,x5,x1` -> `fwd_a` = 1, no stall; after one unrelated instruction -> `fwd_a` = 2; after two -> `fwd_a` = 3.
- Load-use: `lw x7`, then `add x8,x7,x7` -> exactly one cycle of `stall_pc = stall_ifid = bubble_idex = 1`, then `fwd_a = fwd_b = 2`; `stall_cnt` goes 0 -> 1.
- x0 and read flags: writer of `rd = 0` followed by a reader of x0 -> `fwd` = 0; `lui x9` followed by `jal` with `id_rr1 = 0` -> `fwd_a` = 0, no stall.
- Priority: x3 written in EX, MEM and WB simultaneously -> `fwd_a` = 1.
- Flush vs stall collision: load-use condition together with `ex_br_taken = 1` -> `flush_ifid = bubble_idex = 1`, `stall_pc` = 0; `flush_cnt` +1, `stall_cnt` unchanged.
- Reset and saturation:
  - `rst` pulsed during a stall -> all outputs 0 the same cycle, shadow entries invalid on the next edge.
  - Drive 2^`CNT_W` + 3 flushes -> `flush_cnt` holds at all-ones.
